// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared opcodes, control constants, instruction layout and
//               fetch-stage types for the fetch and control units.
// Revision    : 1.1
// ============================================================================
package fetch_unit_pkg;

  localparam int unsigned C_ADDR_WIDTH  = 8;
  localparam int unsigned C_INSTR_WIDTH = 16;
  localparam int unsigned C_OP_WIDTH    = 3;
  localparam int unsigned C_REG_WIDTH   = 3;
  localparam int unsigned C_IMM_WIDTH   = 4;

  localparam logic [C_OP_WIDTH-1:0] OP_ADD  = 3'd0;
  localparam logic [C_OP_WIDTH-1:0] OP_ADDI = 3'd1;
  localparam logic [C_OP_WIDTH-1:0] OP_SUB  = 3'd2;
  localparam logic [C_OP_WIDTH-1:0] OP_AND  = 3'd3;
  localparam logic [C_OP_WIDTH-1:0] OP_OR   = 3'd4;
  localparam logic [C_OP_WIDTH-1:0] OP_LD   = 3'd5;
  localparam logic [C_OP_WIDTH-1:0] OP_ST   = 3'd6;
  localparam logic [C_OP_WIDTH-1:0] OP_BEQ  = 3'd7;

  localparam int unsigned WR_EN  = 0;
  localparam int unsigned R_TYPE = 1;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned RD_MSB  = 12;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS1_MSB = 9;
  localparam int unsigned RS1_LSB = 7;
  localparam int unsigned RS2_MSB = 6;
  localparam int unsigned RS2_LSB = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    logic [C_ADDR_WIDTH-1:0] pc;
    logic [C_OP_WIDTH-1:0]   opcode;
    logic [C_REG_WIDTH-1:0]  rd;
    logic [C_REG_WIDTH-1:0]  rs1;
    logic [C_REG_WIDTH-1:0]  rs2;
    logic [C_IMM_WIDTH-1:0]  imm;
  } decoded_instr_t;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

  function automatic decoded_instr_t decode_instr(
    input logic [C_ADDR_WIDTH-1:0]  pc,
    input logic [C_INSTR_WIDTH-1:0] instr
  );
    decoded_instr_t d;
    d.pc     = pc;
    d.opcode = instr[OPC_MSB:OPC_LSB];
    d.rd     = instr[RD_MSB:RD_LSB];
    d.rs1    = instr[RS1_MSB:RS1_LSB];
    d.rs2    = instr[RS2_MSB:RS2_LSB];
    d.imm    = instr[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : Single-entry holding buffer for a decoded instruction.
// Revision    : 1.0
// ============================================================================
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           load,
  input  logic           drain,
  input  decoded_instr_t load_data,
  output logic           full,
  output decoded_instr_t data
);

  logic           r_full;
  decoded_instr_t r_data;

  // Load wins over drain so a same-cycle refill keeps the entry occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (flush) begin
      r_full <= 1'b0;
    end else if (load) begin
      r_full <= 1'b1;
      r_data <= load_data;
    end else if (drain) begin
      r_full <= 1'b0;
    end
  end

  assign full = r_full;
  assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC owner and single-outstanding instruction fetcher feeding
//               decoded fields to decode over valid/ready, with redirect.
// Revision    : 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = C_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH = C_INSTR_WIDTH,
  parameter int unsigned           OP_WIDTH    = C_OP_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [OP_WIDTH-1:0]    out_opcode,
  output logic [2:0]             out_rd,
  output logic [2:0]             out_rs1,
  output logic [2:0]             out_rs2,
  output logic [3:0]             out_imm
);

  fetch_state_t          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic                  r_imem_req;
  logic                  r_drop_pending;
  logic                  r_out_valid;
  decoded_instr_t        r_out;

  logic                  w_transfer;
  logic                  w_resp;
  logic                  w_skid_full;
  logic                  w_skid_load;
  logic                  w_skid_drain;
  decoded_instr_t        w_skid_data;
  decoded_instr_t        w_resp_data;

  assign w_transfer  = r_out_valid & out_ready;
  assign w_resp      = imem_valid & (r_state == S_WAIT) & ~r_drop_pending & ~redirect_valid;
  assign w_resp_data = decode_instr(r_pc, imem_rdata);

  // The response parks in the skid only when the output register stays busy.
  assign w_skid_load  = w_resp & r_out_valid & (~out_ready | w_skid_full);
  assign w_skid_drain = w_transfer & w_skid_full & ~redirect_valid;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .load      (w_skid_load),
    .drain     (w_skid_drain),
    .load_data (w_resp_data),
    .full      (w_skid_full),
    .data      (w_skid_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_REQ;
      r_pc           <= RESET_PC;
      r_imem_req     <= 1'b0;
      r_imem_addr    <= '0;
      r_drop_pending <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out          <= '0;
    end else if (redirect_valid) begin
      r_state        <= S_REQ;
      r_pc           <= redirect_pc;
      r_imem_req     <= 1'b0;
      r_out_valid    <= 1'b0;
      // An abandoned request still owes us one response unless it lands now.
      r_drop_pending <= ~imem_valid & ((r_state == S_WAIT) | r_drop_pending);
    end else begin
      r_imem_req <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (r_drop_pending) begin
            if (imem_valid) r_drop_pending <= 1'b0;
          end else if (!w_skid_full) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_resp) begin
            r_pc    <= r_pc + PC_STEP;
            r_state <= S_REQ;
          end
        end
      endcase

      if (w_transfer && w_skid_full) begin
        r_out       <= w_skid_data;
        r_out_valid <= 1'b1;
      end else if (w_resp && (!r_out_valid || w_transfer)) begin
        r_out       <= w_resp_data;
        r_out_valid <= 1'b1;
      end else if (w_transfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_imem_addr;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out.pc;
  assign out_opcode = r_out.opcode;
  assign out_rd     = r_out.rd;
  assign out_rs1    = r_out.rs1;
  assign out_rs2    = r_out.rs2;
  assign out_imm    = r_out.imm;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed scoreboard bench for fetch_unit.
// Revision    : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pc;
  logic [2:0]  out_opcode;
  logic [2:0]  out_rd;
  logic [2:0]  out_rs1;
  logic [2:0]  out_rs2;
  logic [3:0]  out_imm;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode),
    .out_rd         (out_rd),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_imm        (out_imm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_req(input logic [7:0] addr, input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, {24'b0, imem_addr}, {24'b0, addr});
  endtask

  task automatic respond(input logic [15:0] data, input logic [7:0] pc);
    exp_t e;
    tick();
    imem_valid = 1'b1;
    imem_rdata = data;
    e.pc    = pc;
    e.instr = data;
    exp_q.push_back(e);
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  // Scoreboard pop on every accepted transfer, plus hold-stability under stall.
  logic       stall_prev = 1'b0;
  logic [7:0] prev_pc;
  logic [2:0] prev_op;
  logic [3:0] prev_imm;

  always @(negedge clk) begin
    exp_t       e;
    logic [15:0] ins;
    if (rst === 1'b0) begin
      if (stall_prev) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_pc", {24'b0, out_pc}, {24'b0, prev_pc});
        check("stall_opimm", {25'b0, out_opcode, out_imm}, {25'b0, prev_op, prev_imm});
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_output: observed pc=%0h opcode=%0h, expected no output", out_pc, out_opcode);
        end else begin
          e   = exp_q.pop_front();
          ins = e.instr;
          check("sb_pc",     {24'b0, out_pc},     {24'b0, e.pc});
          check("sb_opcode", {29'b0, out_opcode}, {29'b0, ins[15:13]});
          check("sb_rd",     {29'b0, out_rd},     {29'b0, ins[12:10]});
          check("sb_rs1",    {29'b0, out_rs1},    {29'b0, ins[9:7]});
          check("sb_rs2",    {29'b0, out_rs2},    {29'b0, ins[6:4]});
          check("sb_imm",    {28'b0, out_imm},    {28'b0, ins[3:0]});
        end
      end
    end
    stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0) && (redirect_valid === 1'b0);
    prev_pc    = out_pc;
    prev_op    = out_opcode;
    prev_imm   = out_imm;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    imem_valid     = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    tick();
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_req",  {31'b0, imem_req},  32'd0);
    check("rst_imem_addr", {24'b0, imem_addr}, 32'd0);
    check("rst_out_pc",    {24'b0, out_pc},    32'd0);
    check("rst_fields",    {19'b0, out_opcode, out_rd, out_rs1, out_rs2, out_imm}, 32'd0);
    rst = 1'b0;

    // Basic fetch, 1-cycle memory latency
    expect_req(8'h00, "t1_req0");
    respond(16'h2A50, 8'h00);
    check("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check("t1_opcode",    {29'b0, out_opcode}, 32'd1);
    check("t1_rd_rs",     {23'b0, out_rd, out_rs1, out_rs2}, {23'b0, 3'd2, 3'd4, 3'd5});
    expect_req(8'h01, "t1_req1");

    // Backpressure: second response lands in skid, fetching stops
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_req(8'h00, "t2_req0");
    respond(16'h0001, 8'h00);
    expect_req(8'h01, "t2_req1");
    respond(16'h0002, 8'h01);
    for (int i = 0; i < 4; i++) begin
      check("t2_no_req", {31'b0, imem_req}, 32'd0);
      check("t2_hold_pc", {24'b0, out_pc}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t2_skid_valid", {31'b0, out_valid}, 32'd1);
    check("t2_skid_pc",    {24'b0, out_pc},    32'd1);
    tick();
    check("t2_drained", {31'b0, out_valid}, 32'd0);
    expect_req(8'h02, "t2_req2");

    // Reset while waiting; a late response must be ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    check("t6_no_out", {31'b0, out_valid}, 32'd0);
    expect_req(8'h00, "t6_req0");
    tick();
    check("t6_still_no_out", {31'b0, out_valid}, 32'd0);
    respond(16'h0003, 8'h00);

    // Redirect while waiting; stale response arrives later
    expect_req(8'h01, "t3_req1");
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("t3_no_req_a", {31'b0, imem_req}, 32'd0);
    tick();
    check("t3_no_req_b", {31'b0, imem_req}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 16'hFFFF;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    check("t3_no_req_c", {31'b0, imem_req}, 32'd0);
    check("t3_no_out",   {31'b0, out_valid}, 32'd0);
    expect_req(8'h40, "t3_req40");
    respond(16'h1111, 8'h40);

    // Redirect coincident with a response
    expect_req(8'h41, "t4_req41");
    tick();
    imem_valid     = 1'b1;
    imem_rdata     = 16'hEEEE;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    tick();
    imem_valid     = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    tick();
    check("t4_req",      {31'b0, imem_req},  32'd1);
    check("t4_addr",     {24'b0, imem_addr}, 32'h80);
    check("t4_no_out",   {31'b0, out_valid}, 32'd0);
    respond(16'h2222, 8'h80);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    expect_req(8'hFF, "t5_reqff");
    respond(16'h3333, 8'hFF);
    check("t5_out_pc", {24'b0, out_pc}, 32'hFF);
    expect_req(8'h00, "t5_wrap");

    tick();
    tick();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control unit.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Splits each returned instruction word into opcode/rd/rs1/rs2/imm fields and presents them to decode over a valid/ready handshake.
- Supports a branch/jump redirect that flushes in-flight work.

Parameters:
- ADDR_WIDTH, 8, PC and instruction-memory address width.
- INSTR_WIDTH, 16, instruction word width.
- OP_WIDTH, 3, opcode field width; must match the control unit.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per sequential instruction (word addressing).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request strobe, exactly one cycle per request.
- imem_addr  out  ADDR_WIDTH  request address; valid while imem_req=1.
- imem_valid  in  1  response strobe, at least 1 cycle after imem_req.
- imem_rdata  in  INSTR_WIDTH  instruction word; valid while imem_valid=1.
- redirect_valid  in  1  one-cycle pulse that loads a new PC and flushes.
- redirect_pc  in  ADDR_WIDTH  target PC, sampled when redirect_valid=1.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  decode accepts the instruction; transfer occurs when out_valid & out_ready.
- out_pc  out  ADDR_WIDTH  PC of the presented instruction.
- out_opcode  out  OP_WIDTH  instr[15:13].
- out_rd  out  3  instr[12:10].
- out_rs1  out  3  instr[9:7].
- out_rs2  out  3  instr[6:4].
- out_imm  out  4  instr[3:0], raw and unextended.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=RESET_PC; state=S_REQ.
  - out_valid=0, imem_req=0, imem_addr=0, skid empty, drop_pending=0.
  - All out_* field registers=0.
  - Reset mid-transaction abandons the outstanding request; a later imem_valid is ignored because drop_pending is cleared and state is S_REQ.
- FSM states: S_REQ, S_WAIT.
- S_REQ:
  - Issue a request (imem_req=1, imem_addr=pc) only when the skid is empty.
  - Then go to S_WAIT. Otherwise stay in S_REQ with imem_req=0.
- S_WAIT: on imem_valid, the response lands:
  - into the output register if out_valid=0 or a transfer occurs this cycle; otherwise into the 1-entry skid buffer;
  - pc += PC_STEP (wraps modulo 2^ADDR_WIDTH);
  - state goes to S_REQ.
  - The response carries the PC it was fetched from.
- Transfer with skid full: skid moves to the output register in the same cycle, so out_valid stays 1 and the skid is empty next cycle.
- out_* fields and out_valid are registered. Latency is imem response latency + 1 cycle from imem_valid to out_valid.
- out_* must remain stable while out_valid=1 and out_ready=0.
- Redirect has highest priority. On redirect_valid=1:
  - pc=redirect_pc; out_valid=0; skid cleared; state goes to S_REQ.
  - If in S_WAIT with no imem_valid this cycle, set drop_pending=1.
  - A response arriving in the same cycle as the redirect is discarded.
  - Next request uses redirect_pc in the following cycle.
- drop_pending=1: the next imem_valid is discarded and clears drop_pending. No request is issued until it clears.
- Never more than one outstanding request. imem_valid outside S_WAIT with drop_pending=0 is ignored.

Decomposition:
- Shared package (the one already holding OP_* opcodes and WR_EN/R_TYPE constants) gains:
  - instruction field bit positions (OPC_MSB/LSB, RD, RS1, RS2, IMM);
  - a packed decoded-instruction typedef (pc, opcode, rd, rs1, rs2, imm);
  - fetch state enum.
- One sub-module: fetch_skid_buf, a 1-entry buffer holding the decoded-instruction struct with full flag, load and drain controls.

Test Plan:
- Reset, memory returns 0x2A50 at addr 0 with 1-cycle latency, out_ready=1 → out_valid=1 with out_pc=0, opcode=3'b001, rd=2, rs1=4, rs2=5, imm=0; next request addr=1.
- Backpressure: out_ready=0 for 6 cycles, two responses 0x0001@addr0 and 0x0002@addr1 → second held in skid, no third request issued; release → outputs 0x0001 then 0x0002 on consecutive cycles, fields stable while stalled.
- Redirect in S_WAIT (redirect_pc=0x40), stale response 0xFFFF arrives 2 cycles later → 0xFFFF never appears on outputs; next imem_addr=0x40.
- Redirect coincident with imem_valid → response discarded, drop_pending stays 0, request to redirect_pc issued next cycle.
- PC wrap: redirect_pc=0xFF, fetch → out_pc=0xFF, following imem_addr=0x00.
- rst asserted in S_WAIT with later imem_valid → out_valid stays 0, first post-reset request addr=RESET_PC.
